// File: rtl/tl_track_pkg.sv
// TileLink opcode constants and burst-length helper shared by the
// in-flight tracker and its beat counters.
package tl_track_pkg;

   localparam logic [2:0] TL_A_PUTFULL = 3'd0;
   localparam logic [2:0] TL_A_PUTPART = 3'd1;
   localparam logic [2:0] TL_A_ARITH   = 3'd2;
   localparam logic [2:0] TL_A_LOGIC   = 3'd3;
   localparam logic [2:0] TL_A_GET     = 3'd4;
   localparam logic [2:0] TL_A_INTENT  = 3'd5;

   localparam logic [2:0] TL_D_ACK     = 3'd0;
   localparam logic [2:0] TL_D_ACKDATA = 3'd1;
   localparam logic [2:0] TL_D_HINTACK = 3'd2;

   // Beats in a data-carrying message of 2^size bytes.
   function automatic logic [7:0] beats(input logic [2:0] size,
                                        input int unsigned beat_bytes);
      int unsigned bytes;
      bytes = 32'd1 << size;
      if (bytes <= beat_bytes) begin
         beats = 8'd1;
      end else begin
         beats = 8'(bytes / beat_bytes);
      end
   endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Per-channel burst tracker: flags first/last beat and detects
// header fields that change inside a multi-beat burst.
module tl_beat_counter
   import tl_track_pkg::*;
#(
   parameter int SOURCE_W   = 4,
   parameter int BEAT_BYTES = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                fire,
   input  logic                multi,
   input  logic [2:0]          opcode,
   input  logic [2:0]          size,
   input  logic [SOURCE_W-1:0] source,
   output logic                first,
   output logic                last,
   output logic                err
);

   logic [7:0]          cnt_q, cnt_d;
   logic [7:0]          total_q, total_d;
   logic [2:0]          op_q, op_d;
   logic [2:0]          size_q, size_d;
   logic [SOURCE_W-1:0] src_q, src_d;
   logic [7:0]          total;

   always_comb begin
      cnt_d   = cnt_q;
      total_d = total_q;
      op_d    = op_q;
      size_d  = size_q;
      src_d   = src_q;
      first   = fire && (cnt_q == 8'd0);
      last    = 1'b0;
      err     = 1'b0;
      total   = multi ? beats(size, BEAT_BYTES) : 8'd1;
      if (fire) begin
         if (cnt_q == 8'd0) begin
            last    = (total == 8'd1);
            cnt_d   = last ? 8'd0 : 8'd1;
            total_d = total;
            op_d    = opcode;
            size_d  = size;
            src_d   = source;
         end else begin
            // Burst length stays as latched even if the header changes.
            err   = (opcode != op_q) || (size != size_q) ||
                    (source != src_q);
            last  = ((cnt_q + 8'd1) == total_q);
            cnt_d = last ? 8'd0 : cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         total_q <= '0;
         op_q    <= '0;
         size_q  <= '0;
         src_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         total_q <= total_d;
         op_q    <= op_d;
         size_q  <= size_d;
         src_q   <= src_d;
      end
   end

endmodule

// File: rtl/tl_inflight_tracker.sv
// TileLink in-flight source tracker with sticky protocol error flags.
// Watchdog built only with TL_INFLIGHT_TRACKER_TIMEOUT_EN defined.
module tl_inflight_tracker
   import tl_track_pkg::*;
#(
   parameter int SOURCE_W    = 4,
   parameter int BEAT_BYTES  = 4,
   parameter int CNT_W       = SOURCE_W + 1,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                a_valid,
   input  logic                a_ready,
   input  logic [2:0]          a_opcode,
   input  logic [2:0]          a_size,
   input  logic [SOURCE_W-1:0] a_source,
   input  logic                d_valid,
   input  logic                d_ready,
   input  logic [2:0]          d_opcode,
   input  logic [2:0]          d_size,
   input  logic [SOURCE_W-1:0] d_source,
   output logic [CNT_W-1:0]    inflight_cnt,
   output logic                err_dup_src,
   output logic                err_unk_src,
   output logic                err_burst,
   output logic                err_timeout,
   output logic                err_any
);

   localparam int NSRC = 1 << SOURCE_W;

   logic            a_fire, d_fire, a_multi, d_multi;
   logic            a_first, a_last, a_err;
   logic            d_first, d_last, d_err;
   logic            alloc, free, dup, unk;
   logic [NSRC-1:0] map_q, map_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            dup_q, dup_d, unk_q, unk_d;
   logic            bur_q, bur_d, any_q, any_d;
   logic            tmo_d;

   assign a_fire  = a_valid & a_ready;
   assign d_fire  = d_valid & d_ready;
   assign a_multi = (a_opcode == TL_A_PUTFULL) ||
                    (a_opcode == TL_A_PUTPART);
   assign d_multi = (d_opcode == TL_D_ACKDATA);

   tl_beat_counter #(
      .SOURCE_W   (SOURCE_W),
      .BEAT_BYTES (BEAT_BYTES)
   ) u_a_beats (
      .clock   (clock),
      .reset_n (reset_n),
      .fire    (a_fire),
      .multi   (a_multi),
      .opcode  (a_opcode),
      .size    (a_size),
      .source  (a_source),
      .first   (a_first),
      .last    (a_last),
      .err     (a_err)
   );

   tl_beat_counter #(
      .SOURCE_W   (SOURCE_W),
      .BEAT_BYTES (BEAT_BYTES)
   ) u_d_beats (
      .clock   (clock),
      .reset_n (reset_n),
      .fire    (d_fire),
      .multi   (d_multi),
      .opcode  (d_opcode),
      .size    (d_size),
      .source  (d_source),
      .first   (d_first),
      .last    (d_last),
      .err     (d_err)
   );

   // Free before alloc so a same-cycle reuse of a source stays set.
   always_comb begin
      alloc = a_first;
      free  = d_fire & d_last;
      dup   = alloc & map_q[a_source] &
              ~(free & (d_source == a_source));
      unk   = d_first & ~map_q[d_source];
      map_d = map_q;
      if (free) begin
         map_d[d_source] = 1'b0;
      end
      if (alloc) begin
         map_d[a_source] = 1'b1;
      end
      cnt_d = '0;
      for (int i = 0; i < NSRC; i++) begin
         cnt_d = cnt_d + CNT_W'(map_d[i]);
      end
      dup_d = dup_q | dup;
      unk_d = unk_q | unk;
      bur_d = bur_q | (a_fire & a_err) | (d_fire & d_err);
      any_d = dup_d | unk_d | bur_d | tmo_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         map_q <= '0;
         cnt_q <= '0;
         dup_q <= 1'b0;
         unk_q <= 1'b0;
         bur_q <= 1'b0;
         any_q <= 1'b0;
      end else begin
         map_q <= map_d;
         cnt_q <= cnt_d;
         dup_q <= dup_d;
         unk_q <= unk_d;
         bur_q <= bur_d;
         any_q <= any_d;
      end
   end

`ifdef TL_INFLIGHT_TRACKER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] wd_q, wd_d;
   logic             tmo_q;

   always_comb begin
      wd_d = wd_q;
      if ((cnt_q == '0) || d_fire) begin
         wd_d = '0;
      end else if (wd_q != TMO_W'(TIMEOUT_CYC)) begin
         wd_d = wd_q + 1'b1;
      end
      tmo_d = tmo_q | (wd_d == TMO_W'(TIMEOUT_CYC));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wd_q  <= '0;
         tmo_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         tmo_q <= tmo_d;
      end
   end

   assign err_timeout = tmo_q;
`else
   assign tmo_d       = 1'b0;
   assign err_timeout = 1'b0;
`endif

   assign inflight_cnt = cnt_q;
   assign err_dup_src  = dup_q;
   assign err_unk_src  = unk_q;
   assign err_burst    = bur_q;
   assign err_any      = any_q;

endmodule

// File: tb/tb_tl_inflight_tracker.sv
// Scoreboard bench for tl_inflight_tracker; expectations are queued
// per driven cycle and compared one clock later.
module tb_tl_inflight_tracker;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       a_valid = 1'b0, a_ready = 1'b1;
   logic [2:0] a_opcode = '0, a_size = '0;
   logic [3:0] a_source = '0;
   logic       d_valid = 1'b0, d_ready = 1'b1;
   logic [2:0] d_opcode = '0, d_size = '0;
   logic [3:0] d_source = '0;
   logic [4:0] inflight_cnt;
   logic       err_dup_src, err_unk_src, err_burst;
   logic       err_timeout, err_any;

   int n_chk = 0;
   int n_fail = 0;

   localparam logic [4:0] F0 = 5'b00000;
   localparam logic [4:0] FD = 5'b10001;
   localparam logic [4:0] FU = 5'b10010;
   localparam logic [4:0] FB = 5'b10100;
   localparam logic [4:0] FT = 5'b11000;

   typedef struct {
      string      tag;
      logic [4:0] cnt;
      logic [4:0] flg;
   } exp_t;

   exp_t sbq[$];

   tl_inflight_tracker #(
      .SOURCE_W    (4),
      .BEAT_BYTES  (4),
      .CNT_W       (5),
      .TIMEOUT_CYC (16)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .a_valid      (a_valid),
      .a_ready      (a_ready),
      .a_opcode     (a_opcode),
      .a_size       (a_size),
      .a_source     (a_source),
      .d_valid      (d_valid),
      .d_ready      (d_ready),
      .d_opcode     (d_opcode),
      .d_size       (d_size),
      .d_source     (d_source),
      .inflight_cnt (inflight_cnt),
      .err_dup_src  (err_dup_src),
      .err_unk_src  (err_unk_src),
      .err_burst    (err_burst),
      .err_timeout  (err_timeout),
      .err_any      (err_any)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] flags();
      return {err_any, err_timeout, err_burst, err_unk_src, err_dup_src};
   endfunction

   task automatic drive(input string tag,
                        input logic av, input logic [2:0] aop,
                        input logic [2:0] asz, input logic [3:0] asrc,
                        input logic dv, input logic [2:0] dop,
                        input logic [2:0] dsz, input logic [3:0] dsrc,
                        input logic [4:0] ecnt, input logic [4:0] eflg);
      exp_t e;
      e.tag = tag;
      e.cnt = ecnt;
      e.flg = eflg;
      sbq.push_back(e);
      a_valid  = av;
      a_opcode = aop;
      a_size   = asz;
      a_source = asrc;
      d_valid  = dv;
      d_opcode = dop;
      d_size   = dsz;
      d_source = dsrc;
      @(posedge clock);
      #1;
      e = sbq.pop_front();
      check({e.tag, ".cnt"}, 32'(inflight_cnt), 32'(e.cnt));
      check({e.tag, ".flg"}, 32'(flags()), 32'(e.flg));
   endtask

   task automatic idle(input string tag, input logic [4:0] ecnt,
                       input logic [4:0] eflg);
      drive(tag, 0, 0, 0, 0, 0, 0, 0, 0, ecnt, eflg);
   endtask

   task automatic do_reset(input string tag);
      a_valid = 1'b0;
      d_valid = 1'b0;
      a_ready = 1'b1;
      d_ready = 1'b1;
      reset_n = 1'b0;
      #3;
      check({tag, ".rst_cnt"}, 32'(inflight_cnt), 32'd0);
      check({tag, ".rst_flg"}, 32'(flags()), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [4:0] tflg;
      @(posedge clock);
      #1;
      do_reset("init");

      // Get then AccessAckData on source 3
      drive("get3", 1, 3'd4, 3'd2, 4'd3, 0, 0, 0, 0, 5'd1, F0);
      idle("hold3", 5'd1, F0);
      drive("ack3", 0, 0, 0, 0, 1, 3'd1, 3'd2, 4'd3, 5'd0, F0);

      // 4-beat PutFull, source changes on beat 3
      do_reset("burst");
      drive("pf1", 1, 3'd0, 3'd4, 4'd5, 0, 0, 0, 0, 5'd1, F0);
      drive("pf2", 1, 3'd0, 3'd4, 4'd5, 0, 0, 0, 0, 5'd1, F0);
      drive("pf3", 1, 3'd0, 3'd4, 4'd6, 0, 0, 0, 0, 5'd1, FB);
      drive("pf4", 1, 3'd0, 3'd4, 4'd5, 0, 0, 0, 0, 5'd1, FB);
      drive("get9", 1, 3'd4, 3'd2, 4'd9, 0, 0, 0, 0, 5'd2, FB);

      // duplicate source
      do_reset("dup");
      drive("g2a", 1, 3'd4, 3'd2, 4'd2, 0, 0, 0, 0, 5'd1, F0);
      drive("g2b", 1, 3'd4, 3'd2, 4'd2, 0, 0, 0, 0, 5'd1, FD);

      // unknown source on empty map
      do_reset("unk");
      drive("ack7", 0, 0, 0, 0, 1, 3'd0, 3'd2, 4'd7, 5'd0, FU);

      // same-cycle free and reuse of source 4
      do_reset("reuse");
      drive("g4", 1, 3'd4, 3'd2, 4'd4, 0, 0, 0, 0, 5'd1, F0);
      drive("g4ack4", 1, 3'd4, 3'd2, 4'd4, 1, 3'd0, 3'd2, 4'd4, 5'd1, F0);
      drive("ack4", 0, 0, 0, 0, 1, 3'd0, 3'd2, 4'd4, 5'd0, F0);

      // multi-beat D frees on last beat; stalled fires ignored
      do_reset("dmulti");
      drive("g1", 1, 3'd4, 3'd3, 4'd1, 0, 0, 0, 0, 5'd1, F0);
      a_ready = 1'b0;
      d_ready = 1'b0;
      drive("stall", 1, 3'd4, 3'd2, 4'd8, 1, 3'd0, 3'd2, 4'd12, 5'd1, F0);
      a_ready = 1'b1;
      d_ready = 1'b1;
      drive("ad1", 0, 0, 0, 0, 1, 3'd1, 3'd3, 4'd1, 5'd1, F0);
      drive("ad2", 0, 0, 0, 0, 1, 3'd1, 3'd3, 4'd1, 5'd0, F0);

      // reset in the middle of a burst abandons it
      do_reset("mid");
      drive("mb1", 1, 3'd0, 3'd4, 4'd5, 0, 0, 0, 0, 5'd1, F0);
      drive("mb2", 1, 3'd0, 3'd4, 4'd5, 0, 0, 0, 0, 5'd1, F0);
      do_reset("mid2");
      drive("after", 1, 3'd4, 3'd2, 4'd2, 0, 0, 0, 0, 5'd1, F0);

      // watchdog
      do_reset("tmo");
      drive("gt1", 1, 3'd4, 3'd2, 4'd1, 0, 0, 0, 0, 5'd1, F0);
      for (int i = 1; i <= 20; i++) begin
`ifdef TL_INFLIGHT_TRACKER_TIMEOUT_EN
         tflg = (i >= 16) ? FT : F0;
`else
         tflg = F0;
`endif
         idle($sformatf("wd%0d", i), 5'd1, tflg);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tl_inflight_tracker.md
TL_INFLIGHT_TRACKER -- requirements
Module: tl_inflight_tracker

Interface
REQ-001 SHALL have parameter SOURCE_W, default 4: width of a_source/d_source; 2^SOURCE_W trackable sources.
REQ-002 SHALL have parameter BEAT_BYTES, default 4: bytes per data beat (32-bit data bus).
REQ-003 SHALL have parameter CNT_W, default SOURCE_W+1: width of inflight_cnt.
REQ-004 SHALL have port: clock  input  1  sole clock, all state rising-edge.
REQ-005 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports: a_valid, a_ready  input  1 each  A-channel handshake; a_fire = a_valid & a_ready.
REQ-007 SHALL have ports: a_opcode input 3, a_size input 3 (log2 bytes), a_source input SOURCE_W.
REQ-008 SHALL have ports: d_valid, d_ready input 1 each; d_opcode input 3; d_size input 3; d_source input SOURCE_W; d_fire = d_valid & d_ready.
REQ-009 SHALL have port: inflight_cnt  output  CNT_W  number of sources currently outstanding.
REQ-010 SHALL have ports: err_dup_src, err_unk_src, err_burst, err_timeout  output  1 each  sticky error flags.
REQ-011 SHALL have port: err_any  output  1  OR of all four error flags.

Function
REQ-012 SHALL compute beats(size) = 1 when 2^size <= BEAT_BYTES, else 2^size/BEAT_BYTES; multi-beat only for A opcodes 0/1 (PutFull/PutPartial) and D opcode 1 (AccessAckData); all other opcodes single-beat.
REQ-013 SHALL keep an A beat counter: idle at 0; first beat is any a_fire with counter 0; counter returns to 0 after the last beat.
REQ-014 SHALL keep an independent D beat counter with identical rules on d_fire.
REQ-015 SHALL latch opcode/size/source on a first beat and set err_burst if any later beat of that burst differs (A or D).
REQ-016 SHALL set the inflight bit for a_source on the A first beat (request allocated at first beat, not last).
REQ-017 SHALL clear the inflight bit for d_source on the D last beat.
REQ-018 SHALL set err_dup_src on an A first beat whose source bit is set and is not cleared by a D last beat in the same cycle.
REQ-019 SHALL set err_unk_src on a D first beat whose source bit is clear in the pre-cycle bitmap (a same-cycle A allocation does not count).
REQ-020 SHALL still clear/set bitmap bits when an error fires; the error case shall never cause an inflight_cnt underflow or overflow.
REQ-021 SHALL update inflight_cnt registered, one cycle after the fire: +1 alloc, -1 free, unchanged for both or neither.
REQ-022 SHALL hold error flags sticky until reset; all outputs registered, one-cycle latency from the offending fire.
REQ-023 SHALL ignore a_*/d_* fields when the corresponding fire is low.

Reset
REQ-024 SHALL on reset_n low clear bitmap, both beat counters, latched fields, inflight_cnt=0, all error flags=0, err_any=0, timeout counter=0, asynchronously.
REQ-025 SHALL treat reset mid-burst as abandoning the burst; the first fire after release is a first beat.

Configuration
REQ-026 SHALL compile the watchdog only when TL_INFLIGHT_TRACKER_TIMEOUT_EN is defined; parameter TIMEOUT_CYC (default 1024) is the limit.
REQ-027 With the macro: a counter increments each cycle inflight_cnt != 0 and no d_fire, resets to 0 on d_fire or inflight_cnt == 0, saturates, and sets err_timeout when it reaches TIMEOUT_CYC.
REQ-028 Without the macro: no watchdog logic; err_timeout tied to 0.

Structure
REQ-029 SHALL place TileLink opcode constants and the beats() function in shared package tl_track_pkg.
REQ-030 SHALL use one sub-module, tl_beat_counter, instantiated once for A and once for D (first/last beat, latched fields, err_burst contribution).

Verification
REQ-031 SHALL cover: A Get src 3 size 2, then D AccessAckData src 3 size 2 -> inflight_cnt 0->1->0, no errors.
REQ-032 SHALL cover: A PutFull size 4 src 5 (4 beats), source changes to 6 on beat 3 -> err_burst=1, err_any=1 next cycle.
REQ-033 SHALL cover: two A Get with src 2, no D between -> err_dup_src=1 after the second; inflight_cnt stays 1.
REQ-034 SHALL cover: D AccessAck src 7 with empty bitmap -> err_unk_src=1, inflight_cnt stays 0.
REQ-035 SHALL cover: src 4 inflight; same cycle A Get src 4 and D AccessAck src 4 -> no error, inflight_cnt stays 1.
REQ-036 SHALL cover (macro on, TIMEOUT_CYC=16): A Get src 1, no D for 16 cycles -> err_timeout=1; macro off -> err_timeout stays 0.
